// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: sync, start detect, LSB-first assembly, parity/stop check
module uart_rx_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 rx_i,
  input  logic                 baud_tick_i,
  output logic                 baud_ena_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_BREAK = 3'd5;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 perr_out_q, perr_out_d;

  // Idle-high synchroniser for the asynchronous serial line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Frame sequencing; all line sampling happens only on the mid-bit tick
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    perr_d     = perr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_out_d = ferr_out_q;
    perr_out_d = perr_out_q;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick_i) begin
          if (!rx_s) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            acc_d   = 1'b0;
            perr_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (baud_tick_i) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          acc_d   = acc_q ^ rx_s;
          if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
          end
        end
      end
      ST_PAR: begin
        if (baud_tick_i) begin
          perr_d  = (PARITY == 1) ? (acc_q ^ rx_s) : ~(acc_q ^ rx_s);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_tick_i) begin
          data_d     = shift_q;
          ferr_out_d = ~rx_s;
          perr_out_d = (PARITY != 0) ? perr_q : 1'b0;
          valid_d    = 1'b1;
          state_d    = rx_s ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        // A held-low line must return high before a new start is accepted
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_out_q <= 1'b0;
      perr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_out_q <= ferr_out_d;
      perr_out_q <= perr_out_d;
    end
  end

  // The generator is enabled only while a frame is in flight, so it reloads between frames
  assign baud_ena_o = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_PAR)   || (state_q == ST_STOP);
  assign busy_o       = (state_q != ST_IDLE);
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign frame_err_o  = ferr_out_q;
  assign parity_err_o = perr_out_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl (none/even/odd parity instances)
module tb_uart_rx_ctrl;

  localparam int BIT_CLKS = 434;
  localparam int HALF     = 217;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] rx;
  logic [2:0] tick;
  logic [2:0] ena;
  logic [7:0] data [3];
  logic [2:0] valid;
  logic [2:0] ferr;
  logic [2:0] perr;
  logic [2:0] busy;
  int         bcnt [3];

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY(0), .SYNC_STAGES(2)) dut0 (
    .rst(rst), .clk(clk), .rx_i(rx[0]), .baud_tick_i(tick[0]), .baud_ena_o(ena[0]),
    .data_o(data[0]), .valid_o(valid[0]), .frame_err_o(ferr[0]),
    .parity_err_o(perr[0]), .busy_o(busy[0]));
  uart_rx_ctrl #(.DATA_BITS(8), .PARITY(1), .SYNC_STAGES(2)) dut1 (
    .rst(rst), .clk(clk), .rx_i(rx[1]), .baud_tick_i(tick[1]), .baud_ena_o(ena[1]),
    .data_o(data[1]), .valid_o(valid[1]), .frame_err_o(ferr[1]),
    .parity_err_o(perr[1]), .busy_o(busy[1]));
  uart_rx_ctrl #(.DATA_BITS(8), .PARITY(2), .SYNC_STAGES(2)) dut2 (
    .rst(rst), .clk(clk), .rx_i(rx[2]), .baud_tick_i(tick[2]), .baud_ena_o(ena[2]),
    .data_o(data[2]), .valid_o(valid[2]), .frame_err_o(ferr[2]),
    .parity_err_o(perr[2]), .busy_o(busy[2]));

  // Bench baud generators: reload while disabled, first tick HALF clocks after enable
  for (genvar g = 0; g < 3; g++) begin : gen_baud
    always @(posedge clk) begin
      if (!ena[g]) bcnt[g] <= 0;
      else         bcnt[g] <= (bcnt[g] == BIT_CLKS - 1) ? 0 : bcnt[g] + 1;
    end
    assign tick[g] = ena[g] && (bcnt[g] == HALF - 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int idx, input exp_t e);
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drive_bit(input int idx, input logic b, input int n);
    rx[idx] = b;
    repeat (n) @(negedge clk);
  endtask

  // Expected outcome derived from frame content alone; instance idx uses parity mode idx
  task automatic send_frame(input int idx, input logic [7:0] d, input logic pbit, input logic stop);
    exp_t e;
    int   ones;
    ones   = $countones(d) + ((idx != 0) ? int'(pbit) : 0);
    e.data = d;
    e.ferr = ~stop;
    e.perr = (idx == 0) ? 1'b0 : (idx == 1) ? logic'(ones % 2 != 0) : logic'(ones % 2 == 0);
    push_exp(idx, e);
    drive_bit(idx, 1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(idx, d[i], BIT_CLKS);
    if (idx != 0) drive_bit(idx, pbit, BIT_CLKS);
    drive_bit(idx, stop, BIT_CLKS);
  endtask

  // Compare every valid pulse against the model queue of its instance
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        if (valid[i] === 1'b1) begin
          exp_t e;
          int   sz;
          sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
          if (sz == 0) begin
            chk($sformatf("unexpected_valid_%0d", i), 32'd1, 32'd0);
          end else begin
            case (i)
              0:       e = q0.pop_front();
              1:       e = q1.pop_front();
              default: e = q2.pop_front();
            endcase
            chk($sformatf("data_%0d", i), {24'd0, data[i]}, {24'd0, e.data});
            chk($sformatf("frame_err_%0d", i), {31'd0, ferr[i]}, {31'd0, e.ferr});
            chk($sformatf("parity_err_%0d", i), {31'd0, perr[i]}, {31'd0, e.perr});
          end
        end
      end
    end
  end

  task automatic parity_seq(input int idx, input logic exp_first, input logic exp_second);
    send_frame(idx, 8'h07, 1'b1, 1'b1);
    drive_bit(idx, 1'b1, 20);
    chk($sformatf("par_lit1_%0d", idx), {31'd0, perr[idx]}, {31'd0, exp_first});
    send_frame(idx, 8'h07, 1'b0, 1'b1);
    drive_bit(idx, 1'b1, 20);
    chk($sformatf("par_lit2_%0d", idx), {31'd0, perr[idx]}, {31'd0, exp_second});
    chk($sformatf("par_data_%0d", idx), {24'd0, data[idx]}, 32'h07);
  endtask

  initial begin
    rst = 1'b0;
    rx  = 3'b111;
    repeat (5) @(negedge clk);
    chk("rst_busy", {29'd0, busy}, 32'd0);
    chk("rst_ena", {29'd0, ena}, 32'd0);
    chk("rst_valid", {29'd0, valid}, 32'd0);
    chk("rst_data", {24'd0, data[0]}, 32'd0);
    chk("rst_flags", {26'd0, ferr, perr}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Clean 8N1 frame
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    chk("clean_busy_low", {31'd0, busy[0]}, 32'd0);
    chk("clean_data_lit", {24'd0, data[0]}, 32'hA5);
    drive_bit(0, 1'b1, BIT_CLKS);

    // Back-to-back frames with no idle gap
    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    send_frame(0, 8'h3C, 1'b0, 1'b1);
    chk("b2b_data_lit", {24'd0, data[0]}, 32'h3C);
    drive_bit(0, 1'b1, BIT_CLKS);

    // False start: short low pulse
    drive_bit(0, 1'b0, 50);
    chk("fs_busy_high", {31'd0, busy[0]}, 32'd1);
    drive_bit(0, 1'b0, 50);
    drive_bit(0, 1'b1, BIT_CLKS);
    chk("fs_busy_low", {31'd0, busy[0]}, 32'd0);
    chk("fs_ena_low", {31'd0, ena[0]}, 32'd0);

    // Framing error followed by a held-low break
    send_frame(0, 8'h55, 1'b0, 1'b0);
    chk("brk_busy", {31'd0, busy[0]}, 32'd1);
    chk("brk_ena", {31'd0, ena[0]}, 32'd0);
    chk("brk_ferr_lit", {31'd0, ferr[0]}, 32'd1);
    chk("brk_data_lit", {24'd0, data[0]}, 32'h55);
    drive_bit(0, 1'b0, 3 * BIT_CLKS);
    drive_bit(0, 1'b1, BIT_CLKS);
    chk("brk_released", {31'd0, busy[0]}, 32'd0);
    send_frame(0, 8'h12, 1'b0, 1'b1);
    chk("after_brk_ferr", {31'd0, ferr[0]}, 32'd0);
    drive_bit(0, 1'b1, BIT_CLKS);

    // Even and odd parity instances in parallel
    fork
      parity_seq(1, 1'b0, 1'b1);
      parity_seq(2, 1'b1, 1'b0);
    join

    // Reset in the middle of data bit 4 of 0xC3
    drive_bit(0, 1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(0, logic'((8'hC3 >> i) & 8'h01), BIT_CLKS);
    drive_bit(0, 1'b0, 200);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("mid_rst_ena", {31'd0, ena[0]}, 32'd0);
    chk("mid_rst_outs", {22'd0, data[0], valid[0], ferr[0]}, 32'd0);
    rx[0] = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(0, 8'h81, 1'b0, 1'b1);
    drive_bit(0, 1'b1, 20);
    chk("post_rst_data_lit", {24'd0, data[0]}, 32'h81);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART. It synchronises the serial line and detects the start bit.
- It gates the rx baud generator through that generator's enable input and consumes the generator's mid-bit strobe.
- It assembles LSB-first data, checks optional parity and the stop bit, and presents the byte with a one-cycle valid pulse to the downstream logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9).
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- SYNC_STAGES, 2, flip-flop stages in the rx input synchroniser (>=2).

Ports:
- rst  input  1  asynchronous, active-low reset.
- clk  input  1  system clock.
- rx_i  input  1  asynchronous serial input; idle high.
- baud_tick_i  input  1  mid-bit strobe from the rx baud generator, one clk wide.
- baud_ena_o  output  1  enable to the rx baud generator; low forces the generator to reload, so the first tick arrives half a bit period after the rise.
- data_o  output  DATA_BITS  last received data word.
- valid_o  output  1  one-cycle pulse when a frame completes.
- frame_err_o  output  1  stop bit sampled low; qualified by valid_o.
- parity_err_o  output  1  parity mismatch; qualified by valid_o; always 0 when PARITY=0.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, async):
  - Synchroniser stages all 1.
  - State IDLE.
  - baud_ena_o, valid_o, frame_err_o, parity_err_o and busy_o are 0.
  - data_o is 0; shift register and bit counter are 0.
  - Reset asserted mid-frame aborts the frame with no valid_o.
- rx_s is the last synchroniser stage. Only rx_s is used by the FSM.
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
- IDLE:
  - baud_ena_o=0.
  - rx_s==0 -> START, with baud_ena_o=1 from the next cycle.
- START:
  - On baud_tick_i with rx_s==0 -> DATA, bit counter=0.
  - On baud_tick_i with rx_s==1 -> IDLE. This is a glitch/false start: no valid_o, no error.
- DATA:
  - On each baud_tick_i, shift rx_s into the MSB of the shift register (LSB-first line order) and increment the counter.
  - Parity accumulator XORs each bit.
  - On the tick that captures bit DATA_BITS-1 -> PAR if PARITY!=0, else STOP.
- PAR:
  - On baud_tick_i, parity_err = (acc ^ rx_s) for even parity; its inverse for odd parity.
  - Then -> STOP.
- STOP, on baud_tick_i:
  - data_o <= shift register.
  - frame_err_o <= ~rx_s; parity_err_o <= latched parity error.
  - valid_o=1 for exactly the next clk cycle.
  - rx_s==1 -> IDLE. rx_s==0 -> BREAK.
- BREAK:
  - baud_ena_o=0.
  - Wait for rx_s==1, then -> IDLE. This prevents a held-low line from retriggering a start.
- baud_ena_o is high in START, DATA, PAR and STOP.
- baud_ena_o drops in the cycle after the stop tick. The generator reloads, so a start edge arriving immediately after the stop-bit midpoint realigns correctly; back-to-back frames are supported.
- baud_tick_i is ignored in IDLE and BREAK.
- rx_s transitions between ticks are ignored; sampling happens only on the tick, with no majority vote.
- data_o, frame_err_o and parity_err_o hold their values until the next completed frame. They update in the same cycle valid_o rises.
- Latency: valid_o rises 1 clk after the stop-bit tick, which is about 9.5 bit periods (DATA_BITS=8, no parity) after the start edge plus the synchroniser delay.
- Counter width is clog2(DATA_BITS+1). The counter never wraps within a frame.

Test Plan:
- Setup: 50 MHz clk, bench baud generator at 434 clk/bit.
- Clean frame: send 0xA5, 8N1, then idle -> single valid_o pulse; data_o=0xA5; frame_err_o=0; parity_err_o=0; busy_o low within 1 bit after the stop midpoint.
- Back-to-back frames: send 0x00, 0xFF, 0x3C with zero idle between them -> three valid_o pulses, data_o=0x00, 0xFF, 0x3C in order; no error flags.
- False start: drive rx_i low for 100 clk, then high -> FSM returns to IDLE after the first tick; no valid_o; baud_ena_o low again.
- Framing error and break: send 0x55 with stop bit low, hold rx_i low 3 bit times -> valid_o with data_o=0x55 and frame_err_o=1; no further valid_o until rx_i returns high; then frame 0x12 is received cleanly.
- Parity (PARITY=1): send 0x07 with parity bit 1, then with parity bit 0 -> parity_err_o=0 then 1; data_o=0x07 both times. Repeat with PARITY=2 -> flags inverted.
- Reset mid-frame: assert rst during DATA bit 4 of 0xC3 -> all outputs 0 immediately and no valid_o; after release, frame 0x81 is received correctly.
